l1_cache_dm: RTL

L1_CACHE_DM -- requirements
Module: l1_cache_dm

---
 rtl/l1_cache_dm_if.sv | 31 +++
 rtl/l1_cache_dm.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/l1_cache_dm_if.sv
// CPU-side request/response and next-level line-transfer signals of the L1 cache.
// The master modport is the environment (CPU plus memory). The slave modport is the cache.
interface l1_cache_dm_if;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l1_cache_dm.sv
// Direct-mapped write-back L1 cache: 8 sets of 128-bit lines, 16-bit byte address.
// Hits complete in the request cycle. A miss runs an optional writeback, then a fill, then replays as a hit.
module l1_cache_dm (
  input  logic          clk,
  input  logic          reset_n,
  l1_cache_dm_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [7:0]   valid_q, valid_d;
  logic [7:0]   dirty_q, dirty_d;
  logic [8:0]   tag_q  [8];
  logic [127:0] data_q [8];

  logic [2:0]   idx_s;
  logic [2:0]   wsel_s;
  logic [8:0]   tag_s;
  logic [6:0]   boff_s;
  logic         hit_s;
  logic         req_s;
  logic         line_we_s;
  logic         tag_we_s;
  logic [127:0] cur_line_s;
  logic [127:0] merged_s;
  logic [127:0] line_d;
  logic [15:0]  cur_word_s;
  logic         addr_unused_s;

  assign idx_s         = bus.mem_address[6:4];
  assign wsel_s        = bus.mem_address[3:1];
  assign tag_s         = bus.mem_address[15:7];
  assign boff_s        = {wsel_s, 4'b0000};
  assign addr_unused_s = bus.mem_address[0];
  assign cur_line_s    = data_q[idx_s];
  assign cur_word_s    = cur_line_s[boff_s +: 16];
  assign hit_s         = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign req_s         = bus.mem_read | bus.mem_write;
  assign bus.mem_rdata = cur_word_s;

  // Byte-enable merge of the write data into the selected word of the indexed line.
  always_comb begin
    merged_s = cur_line_s;
    merged_s[boff_s +: 16] = {
      bus.mem_byte_enable[1] ? bus.mem_wdata[15:8] : cur_word_s[15:8],
      bus.mem_byte_enable[0] ? bus.mem_wdata[7:0]  : cur_word_s[7:0]
    };
  end

  // Next-state, bus outputs and storage update controls.
  always_comb begin
    state_d          = state_q;
    valid_d          = valid_q;
    dirty_d          = dirty_q;
    line_d           = cur_line_s;
    line_we_s        = 1'b0;
    tag_we_s         = 1'b0;
    bus.mem_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = 16'h0000;
    bus.pmem_wdata   = 128'h0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          if (hit_s) begin
            bus.mem_resp = 1'b1;
            // A simultaneous read and write request is serviced as a write.
            if (bus.mem_write) begin
              line_d          = merged_s;
              line_we_s       = 1'b1;
              dirty_d[idx_s]  = 1'b1;
            end else begin
              line_we_s = 1'b0;
            end
          end else if (valid_q[idx_s] && dirty_q[idx_s]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_q[idx_s], idx_s, 4'b0000};
        bus.pmem_wdata   = cur_line_s;
        if (bus.pmem_resp) begin
          state_d = FILL;
        end else begin
          state_d = WRITEBACK;
        end
      end
      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {bus.mem_address[15:4], 4'b0000};
        if (bus.pmem_resp) begin
          line_d          = bus.pmem_rdata;
          line_we_s       = 1'b1;
          tag_we_s        = 1'b1;
          valid_d[idx_s]  = 1'b1;
          dirty_d[idx_s]  = 1'b0;
          state_d         = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM and per-set valid/dirty bits, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= 8'h00;
      dirty_q <= 8'h00;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays. They are not reset because the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (line_we_s) begin
      data_q[idx_s] <= line_d;
    end
    if (tag_we_s) begin
      tag_q[idx_s] <= tag_s;
    end
  end
endmodule
